// File: rtl/csr_counter_bank.sv
// Machine counter / HPM CSR bank: mcycle, minstret, mhpmcounters, mcountinhibit.
// Define CSR_HPM_OVF_IRQ_EN for sticky overflow flags and the lcofi_o request.
module csr_counter_bank #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [11:0]           ra_i,
  output logic [31:0]           rd_o,
  output logic                  hit_o,
  input  logic                  we_i,
  input  logic [11:0]           wa_i,
  input  logic [31:0]           wd_i,
  input  logic                  ins_ret_inc_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  lcofi_o
);

  localparam int HW = CNT_WIDTH - 32;
  // Bit n set when counter/inhibit slot n exists: CY, IR, HPM3..
  localparam logic [31:0] IMASK =
    32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [CNT_WIDTH-1:0] cnt [32];
  logic [7:0]           sel [32];
  logic [31:0]          inh;
  logic [31:0]          inc;
  logic [255:0]         ev_pad;

  logic [4:0]  wn;
  logic [4:0]  rn;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_inh;
  logic        wr_ev;
  logic [31:0] wlo_v;
  logic [31:0] whi_v;
  logic [31:0] wev_v;
  logic [7:0]  wsel;
  logic        of_rd;
  logic        of_wd;

  // Slot 0 stays zero so sel==0 never counts.
  assign ev_pad = 256'({event_i, 1'b0});

  assign wn     = wa_i[4:0];
  assign rn     = ra_i[4:0];
  assign wr_lo  = we_i && wa_i[11:5] == 7'h58 && IMASK[wn];
  assign wr_hi  = we_i && wa_i[11:5] == 7'h5C && IMASK[wn];
  assign wr_inh = we_i && wa_i == 12'h320;
  assign wr_ev  = we_i && wa_i[11:5] == 7'h19
                  && wn >= 5'd3 && IMASK[wn];
  assign wlo_v  = wr_lo ? (32'd1 << wn) : '0;
  assign whi_v  = wr_hi ? (32'd1 << wn) : '0;
  assign wev_v  = wr_ev ? (32'd1 << wn) : '0;
  assign wsel   = (int'(wd_i[7:0]) > NUM_EVENTS) ? 8'd0 : wd_i[7:0];

  always_comb begin
    inc    = '0;
    inc[0] = !inh[0];
    inc[2] = ins_ret_inc_i && !inh[2];
    for (int i = 3; i < 32; i++)
      inc[i] = IMASK[i] && !inh[i] && ev_pad[sel[i]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
        sel[i] <= '0;
      end
      inh <= '0;
    end else begin
      if (wr_inh) inh <= wd_i & IMASK;
      for (int i = 0; i < 32; i++) begin
        if (IMASK[i]) begin
          if (wlo_v[i])
            cnt[i][31:0] <= wd_i;
          else if (whi_v[i])
            cnt[i][CNT_WIDTH-1:32] <= wd_i[HW-1:0];
          else if (inc[i])
            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
        if (wev_v[i]) sel[i] <= wsel;
      end
    end
  end

`ifdef CSR_HPM_OVF_IRQ_EN
  logic [31:0] of_q;
  logic [31:0] ovf;
  logic        irq_q;

  // Overflow only on a real increment, never on a write cycle.
  always_comb begin
    ovf = '0;
    for (int i = 3; i < 32; i++)
      ovf[i] = IMASK[i] && inc[i] && !wlo_v[i]
               && !whi_v[i] && (&cnt[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      of_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      of_q  <= (of_q & ~wev_v)
               | (wev_v & {32{wd_i[31]}}) | ovf;
      irq_q <= |of_q;
    end
  end

  assign lcofi_o = irq_q;
  assign of_rd   = of_q[rn];
  assign of_wd   = wd_i[31];
`else
  assign lcofi_o = 1'b0;
  assign of_rd   = 1'b0;
  assign of_wd   = 1'b0;
`endif

  logic [CNT_WIDTH-1:0] rc;
  logic                 rlo;
  logic                 rhi;
  logic                 rcsr;
  logic                 byp;
  logic [31:0]          bval;

  assign rc   = cnt[rn];
  assign rlo  = ra_i[11:5] == 7'h58 || ra_i[11:5] == 7'h60;
  assign rhi  = ra_i[11:5] == 7'h5C || ra_i[11:5] == 7'h64;
  assign rcsr = ra_i[11:5] == 7'h19;
  assign byp  = (wr_lo || wr_hi || wr_inh || wr_ev) && wa_i == ra_i;

  always_comb begin
    bval = wd_i;
    if (wr_hi)
      bval = 32'(wd_i[HW-1:0]);
    else if (wr_inh)
      bval = wd_i & IMASK;
    else if (wr_ev)
      bval = {of_wd, 23'd0, wsel};
  end

  always_comb begin
    hit_o = 1'b0;
    rd_o  = '0;
    unique case (1'b1)
      rlo: begin
        hit_o = rn != 5'd1;
        rd_o  = rc[31:0];
      end
      rhi: begin
        hit_o = rn != 5'd1;
        rd_o  = 32'(rc[CNT_WIDTH-1:32]);
      end
      rcsr: begin
        hit_o = rn == 5'd0 || rn >= 5'd3;
        rd_o  = (rn == 5'd0) ? inh
                : {of_rd, 23'd0, sel[rn]};
      end
      default: ;
    endcase
    if (byp) rd_o = bval;
    if (!hit_o) rd_o = '0;
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank (64-bit instance plus a 40-bit one).
module tb_csr_counter_bank;

`ifdef CSR_HPM_OVF_IRQ_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ra;
  logic [31:0] rd;
  logic        hit;
  logic        we;
  logic [11:0] wa;
  logic [31:0] wd;
  logic        ins;
  logic [7:0]  ev;
  logic        lcofi;
  logic [31:0] rd40;
  logic        hit40;
  logic        lc40;

  always #5 clk = ~clk;

  csr_counter_bank dut (
    .clk_i(clk), .rst_i(rst), .ra_i(ra), .rd_o(rd),
    .hit_o(hit), .we_i(we), .wa_i(wa), .wd_i(wd),
    .ins_ret_inc_i(ins), .event_i(ev), .lcofi_o(lcofi)
  );

  csr_counter_bank #(.CNT_WIDTH(40)) u40 (
    .clk_i(clk), .rst_i(rst), .ra_i(ra), .rd_o(rd40),
    .hit_o(hit40), .we_i(we), .wa_i(wa), .wd_i(wd),
    .ins_ret_inc_i(ins), .event_i(ev), .lcofi_o(lc40)
  );

  // kind: 0 rd, 1 hit, 2 lcofi, 3 rd of 40-bit instance
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  exp_t sb[$];
  logic req = 1'b0;
  int   vecs = 0;
  int   fails = 0;
  int   tag = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (req) begin
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: got output, want queued entry");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = rd;
          1:       act = {31'd0, hit};
          2:       act = {31'd0, lcofi};
          default: act = rd40;
        endcase
        vecs++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL chk%0d kind%0d addr %h: got %h want %h",
                   e.tag, e.kind, e.addr, act, e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int k, input logic [11:0] a,
                     input logic [31:0] e);
    ra = a;
    tag++;
    sb.push_back('{k, a, e, tag});
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick(1);
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ra  = '0;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    ins = 1'b0;
    ev  = '0;
    tick(2);
    chk(0, 12'hB00, 32'd0);
    chk(0, 12'hB02, 32'd0);
    chk(1, 12'h7C0, 32'd0);
    chk(2, 12'h000, 32'd0);
    rst = 1'b0;
    tick(10);
    chk(0, 12'hB00, 32'd10);
    chk(0, 12'hC00, 32'd11);
    chk(0, 12'hB02, 32'd0);
    chk(0, 12'hB80, 32'd0);

    // carry across halves, then width clip on the 40-bit copy
    wr(12'hB80, 32'h1);
    wr(12'hB00, 32'hFFFF_FFFF);
    tick(1);
    chk(0, 12'hB00, 32'd0);
    chk(0, 12'hB80, 32'd2);
    wr(12'hB80, 32'hFFFF_FFFF);
    chk(0, 12'hB80, 32'hFFFF_FFFF);
    chk(3, 12'hB80, 32'h0000_00FF);

    // inhibit CY and IR while instructions retire
    ins = 1'b1;
    wr(12'h320, 32'h5);
    wr(12'hB00, 32'h1234);
    wr(12'hB80, 32'h0);
    wr(12'hB02, 32'h55);
    wr(12'hB82, 32'h0);
    tick(20);
    chk(0, 12'hB00, 32'h1234);
    chk(0, 12'hB02, 32'h55);
    chk(0, 12'h320, 32'h5);
    wr(12'h320, 32'h0);
    chk(0, 12'hB00, 32'h1234);
    chk(0, 12'hB02, 32'h56);
    chk(0, 12'hB00, 32'h1236);
    wr(12'h320, 32'h2);
    chk(0, 12'h320, 32'h0);
    wr(12'h320, 32'hFFFF_FFFF);
    chk(0, 12'h320, 32'h7D);
    wr(12'h320, 32'h0);

    // write beats increment, same-cycle bypass
    we = 1'b1;
    wa = 12'hB02;
    wd = 32'h100;
    chk(0, 12'hB02, 32'h100);
    we = 1'b0;
    chk(0, 12'hB02, 32'h100);
    ins = 1'b0;

    // read-only shadow ignores writes and does not bypass
    wr(12'h320, 32'h1);
    wr(12'hB00, 32'h77);
    we = 1'b1;
    wa = 12'hC00;
    wd = 32'hDEAD;
    chk(0, 12'hC00, 32'h77);
    we = 1'b0;
    chk(0, 12'hB00, 32'h77);
    wr(12'h320, 32'h0);

    // decode boundaries
    chk(1, 12'h33F, 32'd1);
    chk(0, 12'h33F, 32'd0);
    chk(1, 12'hB01, 32'd0);
    chk(1, 12'h321, 32'd0);
    chk(1, 12'hC9F, 32'd1);
    wr(12'hB1F, 32'h5);
    chk(0, 12'hB1F, 32'd0);

    // event selection
    wr(12'h323, 32'd3);
    ev = 8'h04;
    tick(5);
    ev = 8'h01;
    tick(5);
    ev = 8'h00;
    chk(0, 12'hB03, 32'd5);
    chk(0, 12'h323, 32'd3);
    wr(12'h323, 32'd200);
    chk(0, 12'h323, 32'd0);
    ev = 8'h04;
    tick(3);
    ev = 8'h00;
    chk(0, 12'hB03, 32'd5);
    we = 1'b1;
    wa = 12'h323;
    wd = 32'd9;
    chk(0, 12'h323, 32'd0);
    we = 1'b0;
    chk(0, 12'h323, 32'd0);
    wr(12'h324, 32'd8);
    ev = 8'h80;
    tick(2);
    ev = 8'h00;
    chk(0, 12'hB04, 32'd2);
    wr(12'h324, 32'h8000_0008);
    chk(0, 12'h324, FEAT ? 32'h8000_0008 : 32'h8);
    wr(12'h324, 32'h8);
    tick(2);

    // overflow of HPM3
    wr(12'h323, 32'd1);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    chk(2, 12'h000, 32'd0);
    ev = 8'h01;
    tick(1);
    ev = 8'h00;
    chk(0, 12'hB03, 32'd0);
    chk(2, 12'h000, {31'd0, FEAT});
    chk(0, 12'hB83, 32'd0);
    chk(0, 12'h323, FEAT ? 32'h8000_0001 : 32'h1);
    wr(12'h323, 32'd1);
    tick(1);
    chk(2, 12'h000, 32'd0);

    // reset beats a concurrent write
    wr(12'h324, 32'h8000_0002);
    rst = 1'b1;
    we  = 1'b1;
    wa  = 12'hB00;
    wd  = 32'h55;
    tick(1);
    rst = 1'b0;
    we  = 1'b0;
    chk(0, 12'hB00, 32'd0);
    chk(0, 12'h324, 32'd0);
    chk(2, 12'h000, 32'd0);
    chk(0, 12'h320, 32'd0);

    tick(2);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_left: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
